timer_tick_scheduler: RTL

//  Avalon-MM master sequencing one 16-bit-register interval timer slave: programs period, starts/stops,

---
 rtl/timer_pkg.sv | 34 +++
 rtl/timer_tick_divider.sv | 31 +++
 rtl/timer_tick_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Register map, control word bits and sequencer states shared by the timer tick scheduler.
package timer_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIODL = 3'd2;
    localparam logic [2:0] REG_PERIODH = 3'd3;
    localparam logic [2:0] REG_SNAPL   = 3'd4;
    localparam logic [2:0] REG_SNAPH   = 3'd5;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    localparam logic [15:0] CTL_RUN_WORD  = 16'((1 << CTL_START) | (1 << CTL_CONT) | (1 << CTL_ITO));
    localparam logic [15:0] CTL_STOP_WORD = 16'(1 << CTL_STOP);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTL,
        S_RUN,
        S_CLR_TO,
        S_CLR_WAIT,
        S_STOP,
        S_SNAP_WR,
        S_SNAP_RDL,
        S_SNAP_RDH,
        S_SNAP_CAP
    } state_e;

endpackage

// File: rtl/timer_tick_divider.sv
// One event channel: counts timer ticks and pulses expire every max(div,1) ticks while enabled.
module timer_tick_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             tick,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             expire
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] lim;

    // Compare the pre-increment count so a ratio of N fires on every Nth tick.
    assign lim    = (div == '0) ? '0 : div - 1'b1;
    assign expire = tick & en & (cnt >= lim);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= expire ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_tick_scheduler.sv
// Avalon-MM master that programs, services and snapshots a 16-bit-register interval timer,
// fanning each serviced timeout out to NUM_CH divided event channels.
module timer_tick_scheduler
    import timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             cfg_period,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic                    snap_req,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*DIV_W-1:0] ch_div,
    output logic                    running,
    output logic                    busy,
    output logic [31:0]             tick_count,
    output logic [NUM_CH-1:0]       ch_event,
    output logic                    snap_valid,
    output logic [31:0]             snap_value,
    output logic [2:0]              tmr_address,
    output logic                    tmr_chipselect,
    output logic                    tmr_write_n,
    output logic [15:0]             tmr_writedata,
    input  logic [15:0]             tmr_readdata,
    input  logic                    tmr_irq
);

    state_e      state, state_n;
    logic        start_flag, stop_flag, snap_flag;
    logic        start_pend, stop_pend, snap_pend;
    logic        start_take, stop_take, snap_take;
    logic [31:0] period_q;
    logic [15:0] snap_lo;
    logic        tick;

    // A pulse is acted on in the cycle it arrives; the flag only covers a busy FSM.
    assign start_pend = start_flag | cfg_start;
    assign stop_pend  = stop_flag  | cfg_stop;
    assign snap_pend  = snap_flag  | snap_req;
    assign tick       = (state == S_CLR_TO);
    assign busy       = (state != S_IDLE) && (state != S_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n    = state;
        start_take = 1'b0;
        stop_take  = 1'b0;
        snap_take  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_pend) begin
                    state_n    = S_WR_PL;
                    start_take = 1'b1;
                end else if (snap_pend) begin
                    state_n   = S_SNAP_WR;
                    snap_take = 1'b1;
                end
            end
            S_WR_PL:    state_n = S_WR_PH;
            S_WR_PH:    state_n = S_WR_CTL;
            S_WR_CTL:   state_n = S_RUN;
            S_RUN: begin
                if (tmr_irq) begin
                    state_n = S_CLR_TO;
                end else if (stop_pend) begin
                    state_n   = S_STOP;
                    stop_take = 1'b1;
                end else if (snap_pend) begin
                    state_n   = S_SNAP_WR;
                    snap_take = 1'b1;
                end
            end
            S_CLR_TO:   state_n = S_CLR_WAIT;
            S_CLR_WAIT: state_n = S_RUN;
            S_STOP:     state_n = S_IDLE;
            S_SNAP_WR:  state_n = S_SNAP_RDL;
            S_SNAP_RDL: state_n = S_SNAP_RDH;
            S_SNAP_RDH: state_n = S_SNAP_CAP;
            S_SNAP_CAP: state_n = running ? S_RUN : S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_flag <= 1'b0;
            stop_flag  <= 1'b0;
            snap_flag  <= 1'b0;
            running    <= 1'b0;
            period_q   <= 32'd0;
            tick_count <= 32'd0;
            snap_lo    <= 16'd0;
            snap_value <= 32'd0;
            snap_valid <= 1'b0;
        end else begin
            start_flag <= start_pend & ~start_take & ~running;
            stop_flag  <= stop_pend & ~stop_take & running;
            snap_flag  <= snap_pend & ~snap_take;
            if (state == S_WR_PH)     running <= 1'b1;
            else if (state == S_STOP) running <= 1'b0;
            if (start_take) period_q <= (cfg_period == 32'd0) ? 32'd1 : cfg_period;
            if (state == S_WR_PL)     tick_count <= 32'd0;
            else if (tick)            tick_count <= tick_count + 32'd1;
            if (state == S_SNAP_RDH)  snap_lo <= tmr_readdata;
            if (state == S_SNAP_CAP)  snap_value <= {tmr_readdata, snap_lo};
            snap_valid <= (state == S_SNAP_CAP);
        end
    end

    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = REG_STATUS;
        tmr_writedata  = 16'd0;
        unique case (state)
            S_WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = REG_PERIODL;
                tmr_writedata  = period_q[15:0];
            end
            S_WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = REG_PERIODH;
                tmr_writedata  = period_q[31:16];
            end
            S_WR_CTL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = REG_CONTROL;
                tmr_writedata  = CTL_RUN_WORD;
            end
            S_CLR_TO: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = REG_STATUS;
            end
            S_STOP: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = REG_CONTROL;
                tmr_writedata  = CTL_STOP_WORD;
            end
            S_SNAP_WR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = REG_SNAPL;
            end
            S_SNAP_RDL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = REG_SNAPL;
            end
            S_SNAP_RDH: begin
                tmr_chipselect = 1'b1;
                tmr_address    = REG_SNAPH;
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_tick_divider #(.DIV_W(DIV_W)) u_div (
            .clk    (clk),
            .reset_n(reset_n),
            .clr    (state == S_WR_PL),
            .tick   (tick),
            .en     (ch_en[g]),
            .div    (ch_div[g*DIV_W +: DIV_W]),
            .expire (ch_event[g])
        );
    end

endmodule
